// File: rtl/poly_store.sv
// Single-polynomial coefficient store: serial load, serial unload, parallel view.
// Coefficient i lives in poly_reg[i*b +: b]; the FSM walks one shared slot counter.
module poly_store #(
   parameter int p    = 17,
   parameter int N    = 8,
   parameter int logN = 3,
   parameter int b    = 5,
   parameter int Nb   = N*b
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          WRITE,
   input  logic          data_in_ready,
   input  logic [b-1:0]  data_in,
   input  logic          READ,
   output logic          data_out_ready,
   output logic [b-1:0]  data_out,
   output logic [Nb-1:0] poly_reg
);

   if ((1 << logN) < N || p < 2) begin : g_param_chk
      $error("poly_store: logN too small for N, or modulus p below 2");
   end

   typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;

   state_t          r_state, w_next;
   logic [logN-1:0] r_cnt;
   logic            w_last;
   logic            w_adv;
   logic [b-1:0]    w_slot;

   assign w_last = (r_cnt == logN'(N-1));
   assign w_adv  = ((r_state == LOAD) && data_in_ready) || (r_state == UNLOAD);

   always_comb begin
      w_slot = '0;
      for (int i = 0; i < N; i++)
         if (r_cnt == logN'(i)) w_slot = poly_reg[i*b +: b];
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (WRITE) w_next = LOAD;
                  else if (READ) w_next = UNLOAD;
         LOAD:    if (data_in_ready && w_last) w_next = IDLE;
         UNLOAD:  if (w_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Counter wraps to 0 on the last word so a new session always starts at slot 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                r_cnt <= '0;
      else if (r_state == IDLE)  r_cnt <= '0;
      else if (w_adv)            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out_ready <= 1'b0;
         data_out       <= '0;
      end else begin
         data_out_ready <= (r_state == UNLOAD);
         data_out       <= (r_state == UNLOAD) ? w_slot : '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) poly_reg <= '0;
      else if ((r_state == LOAD) && data_in_ready) begin
         for (int i = 0; i < N; i++)
            if (r_cnt == logN'(i)) poly_reg[i*b +: b] <= data_in;
      end
   end

endmodule

// File: tb/tb_poly_store.sv
// Randomised bench for poly_store against an array model of the coefficient slots.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_poly_store;
   localparam int N  = 8;
   localparam int B  = 5;
   localparam int NB = N*B;

   logic          clk = 1'b0;
   logic          reset;
   logic          WRITE, READ, data_in_ready;
   logic [B-1:0]  data_in;
   logic          data_out_ready;
   logic [B-1:0]  data_out;
   logic [NB-1:0] poly_reg;

   int            n_chk  = 0;
   int            n_fail = 0;
   int unsigned   mdl [N];
   int unsigned   wds [N];

   poly_store #(.p(17), .N(N), .logN(3), .b(B), .Nb(NB)) dut (
      .clk(clk), .reset(reset), .WRITE(WRITE), .data_in_ready(data_in_ready),
      .data_in(data_in), .READ(READ), .data_out_ready(data_out_ready),
      .data_out(data_out), .poly_reg(poly_reg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_poly();
      logic [63:0] v = '0;
      for (int i = 0; i < N; i++) v = v + (64'(mdl[i]) << (i*B));
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load wds[] into the store; optional random stalls and stray READ pulses.
   task automatic do_load(input bit both, input bit stalls);
      WRITE = 1'b1; READ = both; data_in_ready = 1'b1; data_in = B'($urandom);
      tick();
      WRITE = 1'b0; READ = 1'b0;
      for (int k = 0; k < N; k++) begin
         int ns = stalls ? ((k == 3) ? 2 : $urandom_range(0, 1)) : 0;
         for (int s = 0; s < ns; s++) begin
            data_in_ready = 1'b0; data_in = B'($urandom); READ = 1'($urandom);
            tick();
            chk("load_stall_poly", 64'(poly_reg), exp_poly());
         end
         data_in_ready = 1'b1; data_in = B'(wds[k]); READ = stalls ? 1'($urandom) : 1'b0;
         tick();
         mdl[k] = wds[k];
         chk("load_poly", 64'(poly_reg), exp_poly());
         chk("load_dor", 64'(data_out_ready), 64'd0);
      end
      READ = 1'b0;
      // Back in IDLE: further qualified data must not be written.
      data_in = B'($urandom);
      tick();
      data_in_ready = 1'b0;
      chk("post_load_poly", 64'(poly_reg), exp_poly());
   endtask

   task automatic do_read(input int gap);
      logic [63:0] snap = exp_poly();
      repeat (gap) tick();
      READ = 1'b1;
      tick();
      READ = 1'b0;
      chk("read_start_dor", 64'(data_out_ready), 64'd0);
      for (int k = 0; k < N; k++) begin
         WRITE = (k < N-1) ? 1'($urandom) : 1'b0;
         tick();
         chk("read_data", 64'(data_out), 64'(mdl[k]));
         chk("read_dor", 64'(data_out_ready), 64'd1);
      end
      WRITE = 1'b0;
      tick();
      chk("read_end_dor", 64'(data_out_ready), 64'd0);
      chk("read_end_data", 64'(data_out), 64'd0);
      chk("read_poly", 64'(poly_reg), snap);
   endtask

   initial begin
      reset = 1'b0; WRITE = 1'b0; READ = 1'b0; data_in_ready = 1'b0; data_in = '0;
      for (int i = 0; i < N; i++) mdl[i] = 0;

      // Reset hold and quiet idle
      repeat (10) tick();
      chk("rst_poly", 64'(poly_reg), 64'd0);
      chk("rst_dout", 64'(data_out), 64'd0);
      chk("rst_dor", 64'(data_out_ready), 64'd0);
      reset = 1'b1;
      repeat (3) tick();
      chk("idle_poly", 64'(poly_reg), 64'd0);
      chk("idle_dor", 64'(data_out_ready), 64'd0);

      // Directed load 1..8 and read back
      for (int i = 0; i < N; i++) wds[i] = i + 1;
      do_load(1'b0, 1'b0);
      chk("load_1to8", 64'(poly_reg), 64'({5'd8,5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1}));
      do_read(3);

      // Stalls, stray READ, WRITE+READ together
      for (int i = 0; i < N; i++) wds[i] = $urandom_range(0, 31);
      do_load(1'b1, 1'b1);
      do_read($urandom_range(0, 3));

      // Asynchronous reset after 3 words of a load
      for (int i = 0; i < N; i++) wds[i] = $urandom_range(1, 31);
      WRITE = 1'b1; data_in_ready = 1'b1; data_in = B'($urandom);
      tick();
      WRITE = 1'b0;
      for (int k = 0; k < 3; k++) begin
         data_in = B'(wds[k]);
         tick();
         mdl[k] = wds[k];
      end
      chk("pre_rst_poly", 64'(poly_reg), exp_poly());
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < N; i++) mdl[i] = 0;
      chk("mid_rst_poly", 64'(poly_reg), 64'd0);
      chk("mid_rst_dor", 64'(data_out_ready), 64'd0);
      tick();
      reset = 1'b1;
      data_in = B'($urandom);
      tick();
      data_in_ready = 1'b0;
      chk("rst_idle_poly", 64'(poly_reg), 64'd0);
      for (int i = 0; i < N; i++) wds[i] = $urandom_range(0, 31);
      do_load(1'b0, 1'b0);
      do_read(1);

      // Overwrite with alternating 31/0
      for (int i = 0; i < N; i++) wds[i] = (i % 2 == 0) ? 31 : 0;
      do_load(1'b0, 1'b0);
      chk("ovw_slot0", 64'(poly_reg[0 +: B]), 64'd31);
      chk("ovw_slot1", 64'(poly_reg[B +: B]), 64'd0);
      do_read(2);

      // Random sessions
      for (int r = 0; r < 6; r++) begin
         int nw = $urandom_range(1, N);
         for (int i = 0; i < N; i++) wds[i] = $urandom_range(0, 31);
         do_load(1'($urandom), 1'b1);
         do_read($urandom_range(0, 4));
         if (nw == 0) chk("never", 64'd0, 64'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/poly_store.md
Name: poly_store

Overview:
Storage register for one polynomial of N coefficients, each b bits wide. A WRITE command loads N coefficients serially from a b-bit stream. A READ command streams them back out serially. The whole polynomial is also exposed in parallel on poly_reg, so arithmetic blocks in the polynomial datapath can read it directly.

Parameters:
p, 17, coefficient modulus; informational only, no arithmetic uses it.
N, 8, number of coefficients.
logN, 3, counter width; must satisfy 2^logN >= N.
b, 5, coefficient width in bits.
Nb, N*b, width of the flattened polynomial.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (asserted when 0).
WRITE  input  1  command: start a load session; sampled only in IDLE.
data_in_ready  input  1  qualifies data_in during LOAD.
data_in  input  b  serial coefficient input.
READ  input  1  command: start an unload session; sampled only in IDLE.
data_out_ready  output  1  high while data_out carries a valid coefficient.
data_out  output  b  serial coefficient output.
poly_reg  output  Nb  stored polynomial; coefficient i occupies poly_reg[i*b +: b].

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE, counter = 0.
  - poly_reg, data_out and data_out_ready all cleared to 0.
  - Applies immediately, including in the middle of a LOAD or UNLOAD session.
- FSM states: IDLE, LOAD, UNLOAD. All transitions occur on the rising edge of clk.
- IDLE:
  - WRITE=1 -> LOAD, counter=0.
  - else READ=1 -> UNLOAD, counter=0.
  - WRITE has priority when both are high.
  - The data_in value present in the cycle WRITE is sampled is not stored.
- LOAD:
  - Each edge with data_in_ready=1: slot[counter] <= data_in, counter++.
  - data_in_ready=0 stalls the session; nothing is written and counter holds.
  - After slot N-1 is written -> IDLE.
  - WRITE and READ are ignored while in LOAD.
  - Unwritten slots keep their previous contents; there is no clear on a new session.
- UNLOAD:
  - For N consecutive cycles starting the edge after READ was sampled, registered outputs give data_out = slot[counter] and data_out_ready = 1, then counter++.
  - After slot N-1 is presented, the next edge returns to IDLE with data_out_ready = 0 and data_out = 0.
  - WRITE and READ are ignored while in UNLOAD.
  - Unloading is non-destructive; poly_reg is unchanged.
- Outside UNLOAD: data_out = 0 and data_out_ready = 0.
- poly_reg is a direct register output. It updates on the same edge a slot is written, so latency is 0 cycles after that edge.
- Counter wrap: counter never exceeds N-1; the session ends exactly at N words.
- No modular reduction is applied; data_in is stored verbatim.

Test Plan:
1. Reset: hold reset=0 for 10 cycles -> poly_reg=0, data_out=0, data_out_ready=0; release with no commands -> all outputs stay 0.
2. Load:
   - Stimulus: WRITE=1 for 1 cycle (data_in_ready=1, data_in=X), then data_in=1..8 on 8 consecutive cycles.
   - Required: poly_reg = {5'd8,5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1}; FSM back in IDLE.
   - Required: data_out_ready stays 0 throughout.
3. Read:
   - Stimulus: after test 2, wait 3 cycles, then READ=1 for 1 cycle.
   - Required: on the next 8 cycles data_out = 1,2,...,8 with data_out_ready=1; then data_out_ready=0 and data_out=0.
   - Required: poly_reg is unchanged.
4. Stall and ignored commands:
   - During LOAD, drop data_in_ready for 2 cycles between words 3 and 4 -> those cycles are skipped and all 8 words still land in slots 0..7.
   - READ pulsed during LOAD -> ignored.
   - WRITE and READ asserted together in IDLE -> LOAD is entered.
5. Reset mid-operation:
   - Assert reset=0 asynchronously, off the clock edge, after 3 words of a LOAD -> poly_reg=0 immediately and state=IDLE.
   - A following full LOAD and READ behave as in tests 2 and 3.
6. Overwrite:
   - A second load with data_in = 31,0,31,0,... -> poly_reg reflects the new values; slot0=31, slot1=0.
   - A subsequent READ streams 31,0,31,0,31,0,31,0.
